seg_pattern_decoder: RTL and testbench

Receive-side checker for the seven-segment cathode bus. It samples the active-low 7-bit cathode pattern and requires each pattern to be stable before accepting it. Each accepted pattern is decoded back to a BCD digit, and the block measures how long each digit was displayed and flags illegal patterns and broken 0→9 counting sequences. It sits on the board-loopback/self-test path next to the cathode driver; its outputs feed the status LEDs and the test bench scoreboard.

---
 rtl/seg_pattern_decoder.sv | 137 +++++++++++++
 tb/tb_seg_pattern_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_decoder.sv
// Seven-segment cathode loopback checker: debounce, decode, dwell and sequence check.
// Define SEG_SEQ_CHECK_EN to enable the 0..9 counting-sequence checker.
module seg_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DWELL_W       = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         cathode_in,
    output logic [3:0]         digit,
    output logic               digit_valid,
    output logic               blank,
    output logic               pattern_err,
    output logic               seq_err,
    output logic [DWELL_W-1:0] dwell
);

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    typedef enum logic {
        EMPTY,
        LOCKED
    } state_t;

    state_t             state;
    logic [6:0]         cand;
    logic [6:0]         acc;
    logic [7:0]         stabCnt;
    logic [DWELL_W-1:0] dwellCnt;
    logic               accept;
    logic               isDigit;
    logic [3:0]         decDigit;

    assign accept = (stabCnt == STAB_MAX) && (cand != acc);

    always_comb begin
        isDigit  = 1'b1;
        decDigit = 4'd0;
        unique case (cand)
            7'b0000001: decDigit = 4'd0;
            7'b1001111: decDigit = 4'd1;
            7'b0010010: decDigit = 4'd2;
            7'b0000110: decDigit = 4'd3;
            7'b1001100: decDigit = 4'd4;
            7'b0100100: decDigit = 4'd5;
            7'b0100000: decDigit = 4'd6;
            7'b0001111: decDigit = 4'd7;
            7'b0000000: decDigit = 4'd8;
            7'b0000100: decDigit = 4'd9;
            default:    isDigit  = 1'b0;
        endcase
    end

    // Any change restarts the stability window; acc blocks re-acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand    <= PAT_BLANK;
            stabCnt <= 8'd0;
            acc     <= PAT_BLANK;
        end else begin
            if (cathode_in != cand) begin
                cand    <= cathode_in;
                stabCnt <= 8'd0;
            end else if (stabCnt != STAB_MAX) begin
                stabCnt <= stabCnt + 8'd1;
            end
            if (accept) begin
                acc <= cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwellCnt <= '0;
            dwell    <= '0;
        end else if (accept) begin
            dwell    <= dwellCnt;
            dwellCnt <= DWELL_W'(1);
        end else if (dwellCnt != '1) begin
            dwellCnt <= dwellCnt + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            blank       <= 1'b1;
            pattern_err <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            unique case (state)
                EMPTY:  if (accept && isDigit) state <= LOCKED;
                LOCKED: if (accept && !isDigit) state <= EMPTY;
            endcase
            if (accept) begin
                if (isDigit) begin
                    digit       <= decDigit;
                    digit_valid <= 1'b1;
                    blank       <= 1'b0;
                end else if (cand == PAT_BLANK) begin
                    blank <= 1'b1;
                end else begin
                    pattern_err <= 1'b1;
                end
            end
        end
    end

`ifdef SEG_SEQ_CHECK_EN
    logic [3:0] prev;
    logic [3:0] nextDigit;

    assign nextDigit = (prev == 4'd9) ? 4'd0 : prev + 4'd1;

    // state is sampled before its update, so a fresh chain never flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= 4'd0;
            seq_err <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (accept && isDigit) begin
                seq_err <= (state == LOCKED) && (decDigit != nextDigit);
                prev    <= decDigit;
            end
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed self-checking bench for seg_pattern_decoder.
// Runs with STABLE_CYCLES=4 and DWELL_W=8 to reach dwell saturation quickly.
module tb_seg_pattern_decoder;

    localparam int DW = 8;

`ifdef SEG_SEQ_CHECK_EN
    localparam logic SKIP_SEQ = 1'b1;
`else
    localparam logic SKIP_SEQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    cathode;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          blank;
    logic          pattern_err;
    logic          seq_err;
    logic [DW-1:0] dwell;

    int checks = 0;
    int errors = 0;
    int dvCount = 0;
    int seqCount = 0;
    int perrCount = 0;
    int base;

    logic [6:0] segTab [10];

    seg_pattern_decoder #(
        .STABLE_CYCLES(4),
        .DWELL_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cathode_in(cathode),
        .digit(digit),
        .digit_valid(digit_valid),
        .blank(blank),
        .pattern_err(pattern_err),
        .seq_err(seq_err),
        .dwell(dwell)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (digit_valid) dvCount++;
        if (seq_err) seqCount++;
        if (pattern_err) perrCount++;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        segTab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0000100};

        // Reset with digit 0 already on the bus
        rst_n   = 1'b0;
        cathode = segTab[0];
        tick(3);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_dv", 32'(digit_valid), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_perr", 32'(pattern_err), 0);
        chk("rst_seq", 32'(seq_err), 0);
        chk("rst_dwell", 32'(dwell), 0);
        rst_n = 1'b1;
        tick(4);
        chk("early_dv", 32'(digit_valid), 0);
        tick(1);
        chk("first_dv", 32'(digit_valid), 1);
        chk("first_digit", 32'(digit), 0);
        chk("first_blank", 32'(blank), 0);
        chk("first_seq", 32'(seq_err), 0);
        chk("first_dwell", 32'(dwell), 4);
        tick(1);
        chk("first_pulse", 32'(digit_valid), 0);

        // Blank, then sweep 0..9,0,1,2,3 at 20-cycle spacing
        cathode = 7'b1111111;
        tick(5);
        chk("blank_on", 32'(blank), 1);
        chk("blank_dv", 32'(digit_valid), 0);
        chk("blank_digit", 32'(digit), 0);
        tick(15);
        base = dvCount;
        for (int i = 0; i < 14; i++) begin
            cathode = segTab[i % 10];
            tick(5);
            chk("sweep_dv", 32'(digit_valid), 1);
            chk("sweep_digit", 32'(digit), 32'(i % 10));
            chk("sweep_seq", 32'(seq_err), 0);
            chk("sweep_dwell", 32'(dwell), 20);
            chk("sweep_blank", 32'(blank), 0);
            tick(1);
            chk("sweep_pulse", 32'(digit_valid), 0);
            tick(14);
        end
        chk("sweep_count", 32'(dvCount - base), 14);
        chk("sweep_seqcnt", 32'(seqCount), 0);

        // 3-cycle glitch of 8 while 3 is displayed
        base    = dvCount;
        cathode = segTab[8];
        tick(3);
        cathode = segTab[3];
        tick(10);
        chk("glitch_dv", 32'(dvCount - base), 0);
        chk("glitch_digit", 32'(digit), 3);
        chk("glitch_perr", 32'(perrCount), 0);

        // Skip 3 -> 5; dwell spans the glitch
        cathode = segTab[5];
        tick(5);
        chk("skip_dv", 32'(digit_valid), 1);
        chk("skip_digit", 32'(digit), 5);
        chk("skip_seq", 32'(seq_err), 32'(SKIP_SEQ));
        chk("skip_dwell", 32'(dwell), 33);
        tick(1);
        chk("skip_pulse", 32'(seq_err), 0);
        tick(14);

        // Invalid pattern
        cathode = 7'b1010101;
        tick(5);
        chk("inv_perr", 32'(pattern_err), 1);
        chk("inv_dv", 32'(digit_valid), 0);
        chk("inv_digit", 32'(digit), 5);
        chk("inv_blank", 32'(blank), 0);
        tick(1);
        chk("inv_pulse", 32'(pattern_err), 0);
        tick(14);
        chk("inv_count", 32'(perrCount), 1);

        // Blank, then 2 starts a fresh chain
        cathode = 7'b1111111;
        tick(5);
        chk("blank2_on", 32'(blank), 1);
        chk("blank2_digit", 32'(digit), 5);
        tick(15);
        cathode = segTab[2];
        tick(5);
        chk("fresh_dv", 32'(digit_valid), 1);
        chk("fresh_digit", 32'(digit), 2);
        chk("fresh_seq", 32'(seq_err), 0);
        chk("fresh_blank", 32'(blank), 0);
        tick(15);

        // Dwell saturation at 8 bits
        cathode = segTab[4];
        tick(5);
        chk("sat4_digit", 32'(digit), 4);
        tick(300);
        cathode = segTab[5];
        tick(5);
        chk("sat_digit", 32'(digit), 5);
        chk("sat_dwell", 32'(dwell), 255);
        chk("sat_seq", 32'(seq_err), 0);
        tick(15);

        // Asynchronous reset with a pattern in flight
        cathode = segTab[3];
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_digit", 32'(digit), 0);
        chk("arst_blank", 32'(blank), 1);
        chk("arst_dwell", 32'(dwell), 0);
        base = dvCount;
        tick(6);
        chk("arst_noevent", 32'(dvCount - base), 0);
        chk("arst_dv", 32'(digit_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
